// File: rtl/mux2to1_l2_rr.sv
// mux2to1_l2_rr: two-lane to one-lane byte multiplexer.
// Each input lane is buffered in a FIFO_DEPTH-entry FIFO; a round-robin arbiter
// drains both FIFOs into one registered valid/ready output stream, tagging each
// byte with its source lane so a downstream demux can rebuild the lanes.
// Optional macro MUX_PARITY_EN adds parity_out = ^{lane_out, data_out}.
module mux2to1_l2_rr #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in0,
  input  logic [DATA_W-1:0] data_in0,
  output logic              ready0,
  input  logic              valid_in1,
  input  logic [DATA_W-1:0] data_in1,
  output logic              ready1,
  input  logic              out_ready,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              lane_out,
`ifdef MUX_PARITY_EN
  output logic              parity_out,
`endif
  output logic              err_ovf
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic {LANE0 = 1'b0, LANE1 = 1'b1} lane_e;

  // lane-indexed views of the two input ports
  logic [1:0]             vin;
  logic [1:0][DATA_W-1:0] din;
  logic [1:0]             rdy;
  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0]             empty;
  logic [1:0][DATA_W-1:0] head;
  logic [1:0][CNT_W-1:0]  cnt_q;

  assign vin    = {valid_in1, valid_in0};
  assign din    = {data_in1, data_in0};
  assign ready0 = rdy[0];
  assign ready1 = rdy[1];

  // arbiter / output register state
  lane_e             state_q, state_d;
  logic              vld_q;
  logic [DATA_W-1:0] data_q;
  logic              lane_q;
  logic              err_q;
  logic              load;
  logic              sel;

  // per-lane FIFO
  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wp_q, rp_q;

    // ready is based on the registered count only, so a same-cycle pop
    // never opens a slot for the incoming byte
    assign rdy[l]   = !reset && (cnt_q[l] < CNT_W'(FIFO_DEPTH));
    assign push[l]  = vin[l] && rdy[l];
    assign empty[l] = (cnt_q[l] == '0);
    assign head[l]  = mem_q[rp_q];

    // storage array; contents need no reset since the count gates reads
    always_ff @(posedge clk) begin
      if (push[l]) mem_q[wp_q] <= din[l];
    end

    // pointers wrap naturally at ADDR_W bits; count tracks occupancy
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wp_q     <= '0;
        rp_q     <= '0;
        cnt_q[l] <= '0;
      end else begin
        if (push[l]) wp_q <= wp_q + ADDR_W'(1);
        if (pop[l])  rp_q <= rp_q + ADDR_W'(1);
        case ({push[l], pop[l]})
          2'b10:   cnt_q[l] <= cnt_q[l] + CNT_W'(1);
          2'b01:   cnt_q[l] <= cnt_q[l] - CNT_W'(1);
          default: cnt_q[l] <= cnt_q[l];
        endcase
      end
    end
  end

  // round-robin pick: preferred lane first; serving the other lane leaves the
  // preference alone because the preferred lane is still owed the next slot
  always_comb begin
    load    = !vld_q || out_ready;
    pop     = 2'b00;
    sel     = state_q;
    state_d = state_q;
    if (load) begin
      if (!empty[state_q]) begin
        sel      = state_q;
        pop[sel] = 1'b1;
        state_d  = lane_e'(~state_q);
      end else if (!empty[~state_q]) begin
        sel      = ~state_q;
        pop[sel] = 1'b1;
      end
    end
  end

  // arbiter state and registered output stage; held while stalled downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LANE0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      lane_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        vld_q <= |pop;
        if (|pop) begin
          data_q <= head[sel];
          lane_q <= sel;
        end
      end
    end
  end

  // sticky overflow flag: a byte offered to a full lane is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else if ((vin[0] && !rdy[0]) || (vin[1] && !rdy[1])) err_q <= 1'b1;
  end

  assign valid_out = vld_q;
  assign data_out  = data_q;
  assign lane_out  = lane_q;
  assign err_ovf   = err_q;

`ifdef MUX_PARITY_EN
  logic par_q;

  // parity over the tagged byte, loaded alongside data_out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_q <= 1'b0;
    else if (load && |pop) par_q <= ^{sel, head[sel]};
  end

  assign parity_out = par_q;
`endif

endmodule

// File: tb/tb_mux2to1_l2_rr.sv
// Testbench for mux2to1_l2_rr: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the lane FIFOs,
// output register and round-robin preference.
module tb_mux2to1_l2_rr;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in0, valid_in1, out_ready;
  logic [DW-1:0] data_in0, data_in1;
  logic          ready0, ready1, valid_out, lane_out, err_ovf;
  logic [DW-1:0] data_out;
`ifdef MUX_PARITY_EN
  logic          parity_out;
`endif

  always #5 clk = ~clk;

  mux2to1_l2_rr #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset),
    .valid_in0(valid_in0), .data_in0(data_in0), .ready0(ready0),
    .valid_in1(valid_in1), .data_in1(data_in1), .ready1(ready1),
    .out_ready(out_ready), .valid_out(valid_out), .data_out(data_out),
    .lane_out(lane_out),
`ifdef MUX_PARITY_EN
    .parity_out(parity_out),
`endif
    .err_ovf(err_ovf)
  );

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  logic [DW-1:0] q0[$], q1[$];
  bit            m_vld, m_lane, m_pref, m_err;
  logic [DW-1:0] m_data;
  logic [8:0]    got_q[$];   // {lane, data} of bytes accepted downstream

  task automatic model_clear();
    q0.delete(); q1.delete();
    m_vld = 0; m_lane = 0; m_pref = 0; m_err = 0; m_data = '0;
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".vld"},  32'(valid_out), 32'(m_vld));
    chk({tag, ".data"}, 32'(data_out),  32'(m_data));
    chk({tag, ".lane"}, 32'(lane_out),  32'(m_lane));
    chk({tag, ".rdy0"}, 32'(ready0),    32'(q0.size() < DEPTH));
    chk({tag, ".rdy1"}, 32'(ready1),    32'(q1.size() < DEPTH));
    chk({tag, ".err"},  32'(err_ovf),   32'(m_err));
`ifdef MUX_PARITY_EN
    chk({tag, ".par"},  32'(parity_out), 32'(^{m_lane, m_data}));
`endif
  endtask

  // one clock: advance the model from the pre-edge inputs, then compare
  task automatic tick(input string tag);
    bit            v0, v1, ordy, take0, take1;
    logic [DW-1:0] d0, d1;
    v0 = valid_in0; v1 = valid_in1; d0 = data_in0; d1 = data_in1; ordy = out_ready;
    if (valid_out && out_ready) got_q.push_back({lane_out, data_out});
    take0 = v0 && (q0.size() < DEPTH);
    take1 = v1 && (q1.size() < DEPTH);
    if ((v0 && !take0) || (v1 && !take1)) m_err = 1;
    if (!m_vld || ordy) begin
      if (m_pref == 0 && q0.size() > 0) begin
        m_data = q0.pop_front(); m_lane = 0; m_vld = 1; m_pref = 1;
      end else if (m_pref == 1 && q1.size() > 0) begin
        m_data = q1.pop_front(); m_lane = 1; m_vld = 1; m_pref = 0;
      end else if (q0.size() > 0) begin
        m_data = q0.pop_front(); m_lane = 0; m_vld = 1;
      end else if (q1.size() > 0) begin
        m_data = q1.pop_front(); m_lane = 1; m_vld = 1;
      end else begin
        m_vld = 0;
      end
    end
    if (take0) q0.push_back(d0);
    if (take1) q1.push_back(d1);
    @(posedge clk);
    #1;
    cmp_all(tag);
  endtask

  task automatic drive(input bit v0, input logic [DW-1:0] d0,
                       input bit v1, input logic [DW-1:0] d1, input bit ordy);
    valid_in0 = v0; data_in0 = d0; valid_in1 = v1; data_in1 = d1; out_ready = ordy;
  endtask

  task automatic chk_got(input string tag, input logic [8:0] exp[$]);
    chk({tag, ".cnt"}, 32'(got_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk($sformatf("%s.b%0d", tag, i), 32'(got_q[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [8:0] exp_q[$];

    // reset held for two clocks with lane 0 offering a byte
    reset = 1'b1;
    drive(1, 8'h55, 0, 8'h00, 1);
    model_clear();
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst.vld",  32'(valid_out), 32'(0));
      chk("rst.data", 32'(data_out),  32'(0));
      chk("rst.lane", 32'(lane_out),  32'(0));
      chk("rst.rdy0", 32'(ready0),    32'(0));
      chk("rst.rdy1", 32'(ready1),    32'(0));
      chk("rst.err",  32'(err_ovf),   32'(0));
    end
    drive(0, 8'h00, 0, 8'h00, 1);
    reset = 1'b0;
    #1;
    chk("rel.rdy0", 32'(ready0), 32'(1));
    chk("rel.rdy1", 32'(ready1), 32'(1));

    // alternation between two simultaneously filled lanes
    got_q.delete();
    drive(1, 8'h10, 1, 8'h0A, 1); tick("alt0");
    chk("alt.lat1", 32'(valid_out), 32'(0));
    drive(1, 8'h12, 1, 8'h14, 1); tick("alt1");
    chk("alt.first", 32'({valid_out, lane_out, data_out}), 32'({1'b1, 1'b0, 8'h10}));
`ifdef MUX_PARITY_EN
    chk("alt.par10", 32'(parity_out), 32'(1));
`endif
    drive(0, 8'h00, 0, 8'h00, 1);
    repeat (5) tick("alt");
    exp_q = '{9'h010, 9'h10A, 9'h012, 9'h114};
    chk_got("alt.seq", exp_q);

    // single lane stream leaves the preference on lane 0
    got_q.delete();
    drive(0, 8'h00, 1, 8'h22, 1); tick("one0");
    drive(0, 8'h00, 1, 8'h2A, 1); tick("one1");
    drive(0, 8'h00, 1, 8'h32, 1); tick("one2");
    drive(0, 8'h00, 0, 8'h00, 1);
    repeat (4) tick("one");
    exp_q = '{9'h122, 9'h12A, 9'h132};
    chk_got("one.seq", exp_q);
    got_q.delete();
    drive(1, 8'h40, 1, 8'h41, 1); tick("tie0");
    drive(0, 8'h00, 0, 8'h00, 1);
    repeat (3) tick("tie");
    exp_q = '{9'h040, 9'h141};
    chk_got("tie.seq", exp_q);

    // backpressure fills lane 0, sixth byte overflows and is dropped
    got_q.delete();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 8'(i), 0, 8'h00, 0); tick("bp");
    end
    chk("bp.rdy0", 32'(ready0), 32'(0));
    chk("bp.hold", 32'(data_out), 32'(8'h01));
    drive(1, 8'h06, 0, 8'h00, 0); tick("bp6");
    chk("bp.err", 32'(err_ovf), 32'(1));
    drive(0, 8'h00, 0, 8'h00, 1);
    repeat (7) tick("bpd");
    exp_q = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005};
    chk_got("bp.seq", exp_q);

    // asynchronous reset pulse with bytes buffered
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'(8'hA0 + i), 0, 8'h00, 0); tick("mr");
    end
    chk("mr.pre", 32'(valid_out), 32'(1));
    drive(0, 8'h00, 0, 8'h00, 1);
    #2 reset = 1'b1;
    #1;
    chk("mr.vld",  32'(valid_out), 32'(0));
    chk("mr.rdy0", 32'(ready0),    32'(0));
    #1 reset = 1'b0;
    model_clear();
    repeat (6) tick("mr.post");
    chk("mr.none", 32'(got_q.size()), 32'(0));

    // randomized traffic with random downstream stalls
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 6,
            8'($urandom), $urandom_range(0, 3) != 0);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
